sp701_tdc_result_buffer: RTL and testbench

Downstream stage of the single-channel TDC core. Captures each completed measurement (time interval in ps, qualified by the core's one-cycle ready pulse) into a small synchronous FIFO for host readout. Maintains running statistics (count, min, max, sum) so firmware can compute mean and jitter without draining every sample. Sits between the TDC core outputs and the register/host interface.

---
 rtl/sp701_tdc_result_buffer.sv | 197 +++++++++++++++++++
 tb/tb_sp701_tdc_result_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sp701_tdc_result_buffer.sv
// TDC result buffer: FIFO for completed measurements plus running count/min/max/sum statistics.
// Optional macro TDC_RESULT_TIMETAG_EN stores a 32-bit coarse timetag alongside each sample.
module sp701_tdc_result_buffer #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned PTR_WIDTH      = 4,
   parameter int unsigned STAT_CNT_WIDTH = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DATA_WIDTH-1:0]              meas_data,
   input  logic                               meas_ready,
`ifdef TDC_RESULT_TIMETAG_EN
   input  logic [31:0]                        timetag,
   output logic [31:0]                        rd_timetag,
`endif
   input  logic                               clear,
   input  logic                               rd_en,
   output logic [DATA_WIDTH-1:0]              rd_data,
   output logic                               rd_valid,
   output logic [PTR_WIDTH:0]                 fifo_count,
   output logic                               fifo_empty,
   output logic                               fifo_full,
   output logic                               overflow_flag,
   output logic [15:0]                        drop_count,
   output logic [STAT_CNT_WIDTH-1:0]          stat_count,
   output logic [DATA_WIDTH-1:0]              stat_min,
   output logic [DATA_WIDTH-1:0]              stat_max,
   output logic [DATA_WIDTH+STAT_CNT_WIDTH-1:0] stat_sum
);

`ifdef TDC_RESULT_TIMETAG_EN
   localparam int unsigned ENTRY_W = DATA_WIDTH + 32;
`else
   localparam int unsigned ENTRY_W = DATA_WIDTH;
`endif
   localparam int unsigned SUM_W = DATA_WIDTH + STAT_CNT_WIDTH;
   localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(FIFO_DEPTH);

   logic [ENTRY_W-1:0]        mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0]        wr_entry_s;
   logic                      mem_we_s;
   logic                      do_wr_s, do_rd_s, drop_s, stat_sat_s;

   logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]        count_q, count_d;
   logic                      empty_q, empty_d, full_q, full_d;
   logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      ovf_q, ovf_d;
   logic [15:0]               drop_q, drop_d;
   logic [STAT_CNT_WIDTH-1:0] scnt_q, scnt_d;
   logic [DATA_WIDTH-1:0]     smin_q, smin_d, smax_q, smax_d;
   logic [SUM_W-1:0]          ssum_q, ssum_d;
`ifdef TDC_RESULT_TIMETAG_EN
   logic [31:0]               rd_tt_q, rd_tt_d;
   assign wr_entry_s = {timetag, meas_data};
`else
   assign wr_entry_s = meas_data;
`endif

   // Next-state logic: clear dominates, then write/read/drop and statistics
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;
      drop_d     = drop_q;
      scnt_d     = scnt_q;
      smin_d     = smin_q;
      smax_d     = smax_q;
      ssum_d     = ssum_q;
`ifdef TDC_RESULT_TIMETAG_EN
      rd_tt_d    = rd_tt_q;
`endif
      // A full FIFO still accepts a write when the same cycle pops the head.
      do_rd_s    = rd_en && !empty_q;
      do_wr_s    = meas_ready && (!full_q || do_rd_s);
      drop_s     = meas_ready && full_q && !do_rd_s;
      stat_sat_s = &scnt_q;
      mem_we_s   = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         drop_d   = 16'h0000;
         scnt_d   = '0;
         smin_d   = '1;
         smax_d   = '0;
         ssum_d   = '0;
      end else begin
         mem_we_s = do_wr_s;
         if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_rd_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_WIDTH'(1);
            rd_data_d  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
            rd_valid_d = 1'b1;
`ifdef TDC_RESULT_TIMETAG_EN
            rd_tt_d    = mem_q[rd_ptr_q][ENTRY_W-1:DATA_WIDTH];
`endif
         end else begin
            rd_valid_d = 1'b0;
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
            default: count_d = count_q;
         endcase
         if (drop_s) begin
            ovf_d  = 1'b1;
            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'h0001;
         end else begin
            ovf_d  = ovf_q;
         end
         // Dropped samples still count; everything freezes once the counter saturates.
         if (meas_ready && !stat_sat_s) begin
            scnt_d = scnt_q + STAT_CNT_WIDTH'(1);
            ssum_d = ssum_q + {{STAT_CNT_WIDTH{1'b0}}, meas_data};
            smin_d = (meas_data < smin_q) ? meas_data : smin_q;
            smax_d = (meas_data > smax_q) ? meas_data : smax_q;
         end else begin
            scnt_d = scnt_q;
         end
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
   end

   // Sample storage; no reset needed since entries are only read after being written
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[wr_ptr_q] <= wr_entry_s;
      end
   end

   // Control, status and statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         drop_q     <= 16'h0000;
         scnt_q     <= '0;
         smin_q     <= '1;
         smax_q     <= '0;
         ssum_q     <= '0;
`ifdef TDC_RESULT_TIMETAG_EN
         rd_tt_q    <= 32'h0000_0000;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
         scnt_q     <= scnt_d;
         smin_q     <= smin_d;
         smax_q     <= smax_d;
         ssum_q     <= ssum_d;
`ifdef TDC_RESULT_TIMETAG_EN
         rd_tt_q    <= rd_tt_d;
`endif
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign fifo_count    = count_q;
   assign fifo_empty    = empty_q;
   assign fifo_full     = full_q;
   assign overflow_flag = ovf_q;
   assign drop_count    = drop_q;
   assign stat_count    = scnt_q;
   assign stat_min      = smin_q;
   assign stat_max      = smax_q;
   assign stat_sum      = ssum_q;
`ifdef TDC_RESULT_TIMETAG_EN
   assign rd_timetag    = rd_tt_q;
`endif

endmodule

// File: tb/tb_sp701_tdc_result_buffer.sv
// Scoreboard bench for sp701_tdc_result_buffer: directed writes/reads, overflow, clear and async reset.
module tb_sp701_tdc_result_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] meas_data;
   logic        meas_ready, clear, rd_en;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [4:0]  fifo_count;
   logic        fifo_empty, fifo_full, overflow_flag;
   logic [15:0] drop_count, stat_count;
   logic [31:0] stat_min, stat_max;
   logic [47:0] stat_sum;
`ifdef TDC_RESULT_TIMETAG_EN
   logic [31:0] timetag = 32'h0000_0000;
   logic [31:0] rd_timetag;
`endif

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q [$];

   sp701_tdc_result_buffer dut (
      .clk(clk), .rst_n(rst_n), .meas_data(meas_data), .meas_ready(meas_ready),
`ifdef TDC_RESULT_TIMETAG_EN
      .timetag(timetag), .rd_timetag(rd_timetag),
`endif
      .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .overflow_flag(overflow_flag), .drop_count(drop_count), .stat_count(stat_count),
      .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      meas_ready = 1'b1;
      meas_data  = v;
      tick();
      meas_ready = 1'b0;
   endtask

   task automatic pop(input logic [31:0] v);
      exp_q.push_back(v);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("rd_valid_latency", {63'd0, rd_valid}, 64'd1);
   endtask

   // Monitor: every rd_valid strobe must match the oldest expected sample
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rd_valid: got rd_data %0d, expected no strobe", rd_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               fails++;
               $display("FAIL rd_data: got %0d, expected %0d", rd_data, e);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; meas_data = 32'd0; meas_ready = 1'b0; clear = 1'b0; rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_empty", 64'(fifo_empty), 64'd1);
      check("rst_full", 64'(fifo_full), 64'd0);
      check("rst_min", 64'(stat_min), 64'hFFFF_FFFF);
      check("rst_max", 64'(stat_max), 64'd0);
      check("rst_sum", 64'(stat_sum), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic write / read
      push(32'd1000); push(32'd2500); push(32'd1800);
      check("basic_count", 64'(fifo_count), 64'd3);
      check("basic_min", 64'(stat_min), 64'd1000);
      check("basic_max", 64'(stat_max), 64'd2500);
      check("basic_sum", 64'(stat_sum), 64'd5300);
      check("basic_scnt", 64'(stat_count), 64'd3);
      pop(32'd1000); pop(32'd2500); pop(32'd1800);
      check("basic_empty", 64'(fifo_empty), 64'd1);
      clear = 1'b1; tick(); clear = 1'b0;
      check("clr1_scnt", 64'(stat_count), 64'd0);

      // Overflow
      for (int i = 1; i <= 18; i++) push(32'(i));
      check("ovf_full", 64'(fifo_full), 64'd1);
      check("ovf_count", 64'(fifo_count), 64'd16);
      check("ovf_drop", 64'(drop_count), 64'd2);
      check("ovf_flag", 64'(overflow_flag), 64'd1);
      check("ovf_scnt", 64'(stat_count), 64'd18);
      check("ovf_sum", 64'(stat_sum), 64'd171);
      check("ovf_min", 64'(stat_min), 64'd1);
      check("ovf_max", 64'(stat_max), 64'd18);

      // Simultaneous write+read while full
      exp_q.push_back(32'd1);
      meas_ready = 1'b1; meas_data = 32'd99; rd_en = 1'b1;
      tick();
      meas_ready = 1'b0; rd_en = 1'b0;
      check("full_wr_rd_valid", 64'(rd_valid), 64'd1);
      check("full_wr_rd_count", 64'(fifo_count), 64'd16);
      check("full_wr_rd_drop", 64'(drop_count), 64'd2);
      for (int i = 2; i <= 16; i++) pop(32'(i));
      pop(32'd99);
      check("drain_empty", 64'(fifo_empty), 64'd1);

      // Empty reads
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check("empty_rd_valid", 64'(rd_valid), 64'd0);
      rd_en = 1'b1; meas_ready = 1'b1; meas_data = 32'd42; tick();
      rd_en = 1'b0; meas_ready = 1'b0;
      check("empty_wr_rd_valid", 64'(rd_valid), 64'd0);
      check("empty_wr_rd_count", 64'(fifo_count), 64'd1);
      pop(32'd42);

      // Clear with coincident write and read
      for (int i = 10; i < 15; i++) push(32'(i));
      clear = 1'b1; meas_ready = 1'b1; meas_data = 32'd7; rd_en = 1'b1;
      tick();
      clear = 1'b0; meas_ready = 1'b0; rd_en = 1'b0;
      check("clr_count", 64'(fifo_count), 64'd0);
      check("clr_scnt", 64'(stat_count), 64'd0);
      check("clr_min", 64'(stat_min), 64'hFFFF_FFFF);
      check("clr_max", 64'(stat_max), 64'd0);
      check("clr_rd_valid", 64'(rd_valid), 64'd0);
      check("clr_drop", 64'(drop_count), 64'd0);
      check("clr_ovf", 64'(overflow_flag), 64'd0);

      // Asynchronous reset mid-stream
      for (int i = 100; i < 110; i++) push(32'(i));
      check("pre_rst_count", 64'(fifo_count), 64'd10);
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 64'(fifo_count), 64'd0);
      check("arst_empty", 64'(fifo_empty), 64'd1);
      check("arst_scnt", 64'(stat_count), 64'd0);
      check("arst_sum", 64'(stat_sum), 64'd0);
      check("arst_rd_data", 64'(rd_data), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      push(32'd5);
      pop(32'd5);
      repeat (3) tick();

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
